// File: rtl/piso_tx.sv
// piso_tx -- parallel-in / serial-out transmitter.
//
// Accepts a WIDTH-bit word with a valid/ready handshake and shifts it out
// one bit per clock on d, with d_valid/busy marking frame bits and done
// pulsing on the final bit of each frame. A word accepted during the final
// bit cycle starts the next frame with no idle gap.
//
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// (XOR of the data bits) as the final bit of every frame.
//
// Parameters:
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
// Ports:
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   din         parallel word to serialize
//   load_valid  din holds a word to send
//   load_ready  block accepts din this cycle
//   d           serial data (0 when no frame bit is driven)
//   d_valid     d carries a frame bit this cycle
//   busy        frame in progress (identical to d_valid)
//   done        one-cycle pulse on the final bit of a frame
module piso_tx #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             d,
   output logic             d_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             last_data;
   logic             accept;
   logic             cur_bit;
`ifdef PISO_PARITY_EN
   logic             par;
`endif

   // The bit on d is always the leading end of the shift register, so the
   // output order is set purely by which way the register shifts.
   assign cur_bit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
   assign accept  = load_valid & load_ready;
   assign busy    = d_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      d_valid    = 1'b0;
      d          = 1'b0;
      done       = 1'b0;
      last_data  = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            d_valid   = 1'b1;
            d         = cur_bit;
            last_data = (cnt == LAST);
`ifdef PISO_PARITY_EN
            if (last_data) state_nxt = PARITY;
`else
            // Final data bit ends the frame: offer ready so a waiting word
            // streams straight into the next frame.
            if (last_data) begin
               load_ready = 1'b1;
               done       = 1'b1;
               state_nxt  = load_valid ? SHIFT : IDLE;
            end
`endif
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            d_valid    = 1'b1;
            d          = par;
            load_ready = 1'b1;
            done       = 1'b1;
            state_nxt  = load_valid ? SHIFT : IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shreg <= '0;
         cnt   <= '0;
`ifdef PISO_PARITY_EN
         par   <= 1'b0;
`endif
      end else if (accept) begin
         shreg <= din;
         cnt   <= '0;
`ifdef PISO_PARITY_EN
         // Parity is latched at acceptance because shifting destroys the word.
         par   <= ^din;
`endif
      end else if (state == SHIFT) begin
         shreg <= (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
         cnt   <= last_data ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx -- self-checking bench for piso_tx.
// Two instances (MSB-first and LSB-first, WIDTH=4) share stimulus. A
// queue-of-bits model predicts every output each cycle; directed scenarios
// pin the model with literal expected bit strings.
module tb_piso_tx;

   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam int F = W + 1;
   localparam logic [31:0] E28  = 32'b11011;
   localparam logic [31:0] E30  = 32'b10111;
   localparam logic [31:0] E29  = 32'b110111010011110;
   localparam logic [31:0] E31  = 32'b10100;
   localparam logic [31:0] E32  = 32'b1101100000;
   localparam logic [31:0] E33  = 32'b10010;
   localparam logic [3:0]  ESIPO = 4'b1110;
`else
   localparam int F = W;
   localparam logic [31:0] E28  = 32'b1101;
   localparam logic [31:0] E30  = 32'b1011;
   localparam logic [31:0] E29  = 32'b110110101111;
   localparam logic [31:0] E31  = 32'b1010;
   localparam logic [31:0] E32  = 32'b11010000;
   localparam logic [31:0] E33  = 32'b1001;
   localparam logic [3:0]  ESIPO = 4'b1111;
`endif

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [W-1:0] din = '0;
   logic         load_valid = 1'b0;
   logic         rdy_m, d_m, dv_m, busy_m, done_m;
   logic         rdy_l, d_l, dv_l, busy_l, done_l;

   int checks = 0;
   int errors = 0;

   logic [31:0] rec_d, rec_l, rec_v, rec_dn, rec_r;
   logic [3:0]  sipo = '0;
   logic        qm[$];
   logic        ql[$];

   always #5 clk = ~clk;

   piso_tx #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rstn(rstn), .din(din), .load_valid(load_valid),
      .load_ready(rdy_m), .d(d_m), .d_valid(dv_m), .busy(busy_m), .done(done_m)
   );

   piso_tx #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rstn(rstn), .din(din), .load_valid(load_valid),
      .load_ready(rdy_l), .d(d_l), .d_valid(dv_l), .busy(busy_l), .done(done_l)
   );

   // Reference model: each queue holds the bits still to be sent; the front
   // is the bit on d this cycle. Ready when at most one bit remains.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         qm.delete();
         ql.delete();
      end else begin
         automatic bit rdy = (qm.size() <= 1);
         if (qm.size() > 0) void'(qm.pop_front());
         if (ql.size() > 0) void'(ql.pop_front());
         if (load_valid && rdy) begin
            for (int i = 0; i < W; i++) begin
               qm.push_back(din[W-1-i]);
               ql.push_back(din[i]);
            end
`ifdef PISO_PARITY_EN
            qm.push_back(^din);
            ql.push_back(^din);
`endif
         end
      end
   end

   // Downstream SIPO fed by the MSB-first serial stream.
   always @(posedge clk) begin
      if (dv_m) sipo <= {sipo[2:0], d_m};
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] lo(input logic [31:0] v, input int n);
      return (n >= 32) ? v : (v & ((32'h1 << n) - 32'h1));
   endfunction

   task automatic clr();
      rec_d = '0; rec_l = '0; rec_v = '0; rec_dn = '0; rec_r = '0;
   endtask

   // Apply inputs for one cycle just after the rising edge, then record the
   // outputs of that cycle at the falling edge.
   task automatic step(input logic lv, input logic [W-1:0] dd);
      @(posedge clk);
      #1;
      load_valid = lv;
      din = dd;
      @(negedge clk);
      rec_d  = {rec_d[30:0], d_m};
      rec_l  = {rec_l[30:0], d_l};
      rec_v  = {rec_v[30:0], dv_m};
      rec_dn = {rec_dn[30:0], done_m};
      rec_r  = {rec_r[30:0], rdy_m};
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   initial begin
      fork
         forever begin : cmp
            logic em, vm, dm, rm, el, vl, dl, rl;
            @(negedge clk);
            vm = (qm.size() > 0); em = vm ? qm[0] : 1'b0;
            dm = (qm.size() == 1); rm = (qm.size() <= 1);
            vl = (ql.size() > 0); el = vl ? ql[0] : 1'b0;
            dl = (ql.size() == 1); rl = (ql.size() <= 1);
            checks++;
            if ({d_m, dv_m, busy_m, done_m} !== {em, vm, vm, dm} || (rstn && rdy_m !== rm)) begin
               errors++;
               $display("FAIL msb_cycle t=%0t actual d,v,busy,done,rdy=%b%b%b%b%b required %b%b%b%b%b",
                        $time, d_m, dv_m, busy_m, done_m, rdy_m, em, vm, vm, dm, rm);
            end
            checks++;
            if ({d_l, dv_l, busy_l, done_l} !== {el, vl, vl, dl} || (rstn && rdy_l !== rl)) begin
               errors++;
               $display("FAIL lsb_cycle t=%0t actual d,v,busy,done,rdy=%b%b%b%b%b required %b%b%b%b%b",
                        $time, d_l, dv_l, busy_l, done_l, rdy_l, el, vl, vl, dl, rl);
            end
         end
      join_none

      // Reset state
      #12;
      chk("reset_outputs", {28'b0, d_m, dv_m, busy_m, done_m}, 32'h0);
      @(posedge clk); #1; rstn = 1'b1;
      #1;
      chk("ready_after_release", {31'b0, rdy_m}, 32'h1);
      idle(2);

      // Single frame, both bit orders
      clr();
      step(1'b1, 4'b1101);
      for (int c = 1; c <= F; c++) step(1'b0, '0);
      chk("single_msb_bits", lo(rec_d, F), E28);
      chk("single_lsb_bits", lo(rec_l, F), E30);
      chk("single_valid", lo(rec_v, F), lo(32'hFFFF_FFFF, F));
      chk("single_done", lo(rec_dn, F), 32'h1);
      idle(2);

      // Back-to-back streaming with load_valid held high
      clr();
      for (int c = 0; c <= 3 * F; c++)
         step(c < 3 * F, (c < F) ? 4'b1101 : (c < 2 * F) ? 4'b1010 : 4'b1111);
      chk("stream_bits", lo(rec_d, 3 * F), E29);
      chk("stream_valid", lo(rec_v, 3 * F), lo(32'hFFFF_FFFF, 3 * F));
      chk("stream_done", lo(rec_dn, 3 * F), (32'h1 << (2 * F)) | (32'h1 << F) | 32'h1);
      idle(1);
      chk("stream_sipo", {28'b0, sipo}, {28'b0, ESIPO});
      idle(1);

      // Reset in the middle of a frame
      clr();
      step(1'b1, 4'b1101);
      step(1'b0, '0);
      @(posedge clk); #3;
      chk("pre_reset_busy", {31'b0, busy_m}, 32'h1);
      rstn = 1'b0;
      #1;
      chk("reset_immediate", {25'b0, d_m, dv_m, busy_m, d_l, dv_l, busy_l, done_m}, 32'h0);
      @(posedge clk); #1;
      rstn = 1'b1; load_valid = 1'b1; din = 4'b1010;
      clr();
      for (int c = 1; c <= F; c++) step(1'b0, '0);
      chk("after_reset_bits", lo(rec_d, F), E31);
      chk("after_reset_done", lo(rec_dn, F), 32'h1);
      idle(2);

      // din changes while not ready are ignored
      clr();
      step(1'b1, 4'b1101);
      for (int c = 1; c <= F; c++) step(1'b1, 4'b0000);
      for (int c = 1; c <= F; c++) step(1'b0, 4'b1111);
      chk("ignore_bits", lo(rec_d, 2 * F), E32);
      chk("ignore_valid", lo(rec_v, 2 * F), lo(32'hFFFF_FFFF, 2 * F));
      chk("ignore_ready", lo(rec_r >> F, F), 32'h1);
      idle(2);

      // Second parity value
      clr();
      step(1'b1, 4'b1001);
      for (int c = 1; c <= F; c++) step(1'b0, '0);
      chk("word_1001_bits", lo(rec_d, F), E33);
      idle(2);

      // Randomized traffic with occasional asynchronous resets
      for (int c = 0; c < 600; c++) begin
         @(posedge clk);
         #1;
         rstn = ($urandom_range(0, 59) != 0);
         load_valid = ($urandom_range(0, 3) != 0);
         din = W'($urandom);
      end
      @(posedge clk); #1;
      rstn = 1'b1; load_valid = 1'b0;
      idle(3 * F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
